// File: rtl/muldiv_pkg.sv
// Shared definitions for the EX-stage multiply/divide sequencer.
// Holds the op encodings, FSM state constants and the op-class predicates
// used by both the scheduler and its per-step datapath.
package muldiv_pkg;

   // op_i encodings as issued by EX
   localparam logic [2:0] OP_MUL   = 3'd0;
   localparam logic [2:0] OP_MULH  = 3'd1;
   localparam logic [2:0] OP_MULHU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_REM   = 3'd5;
   localparam logic [2:0] OP_REMU  = 3'd6;
   localparam logic [2:0] OP_RSVD  = 3'd7;

   // Sequencer states
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   // Quotient/remainder ops run the restoring-divide step
   function automatic logic is_div_op(input logic [2:0] op);
      return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
   endfunction

   // Ops whose operands are two's complement and need abs / sign fix-up
   function automatic logic is_signed_op(input logic [2:0] op);
      return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
   endfunction

endpackage

// File: rtl/muldiv_iter_dp.sv
// One radix-2 iteration of the multiply/divide datapath, purely combinational.
// Ports: acc_i (2*WIDTH accumulator), operand_i (multiplicand or divisor),
//        div_mode_i (1 = restoring divide step, 0 = shift-add step), acc_o (next accumulator).
module muldiv_iter_dp #(
   parameter int WIDTH = 32
) (
   input  logic [2*WIDTH-1:0] acc_i,
   input  logic [WIDTH-1:0]   operand_i,
   input  logic               div_mode_i,
   output logic [2*WIDTH-1:0] acc_o
);

   // Multiply layout: {partial product high, multiplier bits still to consume}.
   // Divide layout:   {partial remainder, dividend bits shifting into quotient}.
   logic [WIDTH:0] add_sum;
   logic [WIDTH:0] shifted;
   logic [WIDTH:0] diff;

   always_comb begin
      add_sum = {1'b0, acc_i[2*WIDTH-1:WIDTH]}
              + (acc_i[0] ? {1'b0, operand_i} : {(WIDTH+1){1'b0}});
      shifted = {acc_i[2*WIDTH-1:WIDTH], acc_i[WIDTH-1]};
      diff    = shifted - {1'b0, operand_i};
      acc_o   = '0;
      if (div_mode_i) begin
         // Partial remainder is always below the divisor, so the borrow bit
         // alone tells whether the trial subtraction fits.
         if (!diff[WIDTH]) begin
            acc_o = {diff[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
         end else begin
            acc_o = {shifted[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
         end
      end else begin
         // Add on LSB, then shift the whole accumulator right; the carry
         // lands in the top bit.
         acc_o = {add_sum, acc_i[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/ex_muldiv_sched.sv
// Multi-cycle MUL/DIV sequencer beside the EX ALU: latch op, iterate WIDTH steps, pulse done_o.
// Latency: accept cycle 0, BUSY 1..WIDTH, done_o at WIDTH+1 (special cases: done_o at cycle 1).
// Backpressure: stall_o freezes IF/ID/EX on accept and through BUSY; low in DONE so EX advances.
// Ports: clk/rstn (sync active-low), start_i/op_i/a_i/b_i from EX, flush_i kills the op,
//        stall_o to hazard control, done_o + result_o back to the EX result mux.
module ex_muldiv_sched
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             start_i,
   input  logic [2:0]       op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             flush_i,
   output logic             stall_o,
   output logic             done_o,
   output logic [WIDTH-1:0] result_o
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(WIDTH - 1);
   localparam logic [WIDTH-1:0]   ONE      = WIDTH'(1);
   localparam logic [2*WIDTH-1:0] ONE2     = (2*WIDTH)'(1);
   localparam logic [WIDTH-1:0]   MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

   logic [1:0]         state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [2:0]         op_q, op_d;
   logic [WIDTH-1:0]   a_q, a_d;           // |a| for signed ops, raw a otherwise
   logic [WIDTH-1:0]   b_q, b_d;           // |b| for signed ops, raw b otherwise
   logic               neg_q, neg_d;       // final result must be negated
   logic               spec_q, spec_d;     // op resolved at accept, no iteration
   logic [WIDTH-1:0]   spec_res_q, spec_res_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   result_q, result_d;

   logic               accept;
   logic               sa, sb;
   logic [WIDTH-1:0]   abs_a, abs_b;
   logic               div_zero, sgn_ovf, is_rsvd;
   logic               dp_div_mode;
   logic [WIDTH-1:0]   dp_operand;
   logic [2*WIDTH-1:0] dp_acc;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quot, rem;
   logic [WIDTH-1:0]   fin_res;

   // ---------------- accept-time operand conditioning ----------------
   assign accept = (state_q == S_IDLE) && start_i && !flush_i;

   always_comb begin
      sa       = is_signed_op(op_i) & a_i[WIDTH-1];
      sb       = is_signed_op(op_i) & b_i[WIDTH-1];
      abs_a    = sa ? (~a_i + ONE) : a_i;
      abs_b    = sb ? (~b_i + ONE) : b_i;
      div_zero = is_div_op(op_i) && (b_i == '0);
      // Only signed quotient/remainder can overflow: MIN / -1
      sgn_ovf  = ((op_i == OP_DIV) || (op_i == OP_REM)) && (a_i == MIN_NEG) && (b_i == '1);
      is_rsvd  = (op_i == OP_RSVD);
   end

   // ---------------- per-step datapath ----------------
   assign dp_div_mode = is_div_op(op_q);
   // Multiply adds |a| with |b| in the low half; divide subtracts |b| from |a| shifted in.
   assign dp_operand  = dp_div_mode ? b_q : a_q;

   muldiv_iter_dp #(
      .WIDTH(WIDTH)
   ) u_dp (
      .acc_i      (acc_q),
      .operand_i  (dp_operand),
      .div_mode_i (dp_div_mode),
      .acc_o      (dp_acc)
   );

   // ---------------- sign fix-up and result select ----------------
   always_comb begin
      prod_fix = neg_q ? (~acc_q + ONE2) : acc_q;
      quot     = acc_q[WIDTH-1:0];
      rem      = acc_q[2*WIDTH-1:WIDTH];
      fin_res  = '0;
      case (op_q)
         OP_MUL:            fin_res = prod_fix[WIDTH-1:0];
         OP_MULH, OP_MULHU: fin_res = prod_fix[2*WIDTH-1:WIDTH];
         OP_DIV, OP_DIVU:   fin_res = neg_q ? (~quot + ONE) : quot;
         OP_REM, OP_REMU:   fin_res = neg_q ? (~rem + ONE) : rem;
         default:           fin_res = '0;
      endcase
      if (spec_q) begin
         fin_res = spec_res_q;
      end
   end

   assign stall_o  = accept || (state_q == S_BUSY);
   assign done_o   = (state_q == S_DONE) && !flush_i;
   // Result holds between ops; consumers qualify it with done_o.
   assign result_o = done_o ? fin_res : result_q;

   // ---------------- FSM / next state ----------------
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      op_d       = op_q;
      a_d        = a_q;
      b_d        = b_q;
      neg_d      = neg_q;
      spec_d     = spec_q;
      spec_res_d = spec_res_q;
      acc_d      = acc_q;
      result_d   = result_o;

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               op_d  = op_i;
               a_d   = abs_a;
               b_d   = abs_b;
               // Remainder follows the dividend; product and quotient follow sign mismatch.
               neg_d = ((op_i == OP_REM) || (op_i == OP_REMU)) ? sa : (sa ^ sb);
               acc_d = is_div_op(op_i) ? {{WIDTH{1'b0}}, abs_a} : {{WIDTH{1'b0}}, abs_b};
               if (div_zero || sgn_ovf || is_rsvd) begin
                  spec_d  = 1'b1;
                  state_d = S_DONE;
                  if (is_rsvd) begin
                     spec_res_d = '0;
                  end else if (div_zero) begin
                     spec_res_d = ((op_i == OP_DIV) || (op_i == OP_DIVU)) ? '1 : a_i;
                  end else begin
                     spec_res_d = (op_i == OP_DIV) ? MIN_NEG : '0;
                  end
               end else begin
                  spec_d  = 1'b0;
                  state_d = S_BUSY;
                  cnt_d   = CNT_LAST;
               end
            end
         end
         S_BUSY: begin
            if (flush_i) begin
               state_d = S_IDLE;
            end else begin
               acc_d = dp_acc;
               if (cnt_q == '0) begin
                  state_d = S_DONE;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
         end
         // A start_i still high here belongs to the retiring op; never re-accept.
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         op_q       <= '0;
         a_q        <= '0;
         b_q        <= '0;
         neg_q      <= 1'b0;
         spec_q     <= 1'b0;
         spec_res_q <= '0;
         acc_q      <= '0;
         result_q   <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         op_q       <= op_d;
         a_q        <= a_d;
         b_q        <= b_d;
         neg_q      <= neg_d;
         spec_q     <= spec_d;
         spec_res_q <= spec_res_d;
         acc_q      <= acc_d;
         result_q   <= result_d;
      end
   end

endmodule

// File: tb/tb_ex_muldiv_sched.sv
// Directed self-checking bench for ex_muldiv_sched.
// Cycle 0 is the cycle start_i is presented in IDLE; outputs sampled 1ns after each falling edge.
// Each test task drives its scenario and compares against hand-computed values.
module tb_ex_muldiv_sched;

   localparam logic [2:0] MUL = 3'd0, MULH = 3'd1, MULHU = 3'd2, DIV = 3'd3,
                          DIVU = 3'd4, REM = 3'd5, REMU = 3'd6, RSVD = 3'd7;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        start_i = 1'b0;
   logic [2:0]  op_i = 3'd0;
   logic [31:0] a_i = 32'd0;
   logic [31:0] b_i = 32'd0;
   logic        flush_i = 1'b0;
   logic        stall_o;
   logic        done_o;
   logic [31:0] result_o;

   int total = 0;
   int bad   = 0;

   ex_muldiv_sched #(.WIDTH(32)) dut (
      .clk      (clk),
      .rstn     (rstn),
      .start_i  (start_i),
      .op_i     (op_i),
      .a_i      (a_i),
      .b_i      (b_i),
      .flush_i  (flush_i),
      .stall_o  (stall_o),
      .done_o   (done_o),
      .result_o (result_o)
   );

   always #5 clk = ~clk;

   // Stimulus helper: issue one op, hold start_i until done_o, report observations.
   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int done_at, output int stalls);
      @(negedge clk);
      start_i = 1'b1; op_i = op; a_i = a; b_i = b;
      done_at = -1; stalls = 0; res = '0;
      for (int c = 0; c < 100; c++) begin
         #1;
         if (stall_o) stalls++;
         if (done_o) begin
            done_at = c; res = result_o;
            break;
         end
         @(negedge clk);
      end
      @(negedge clk);
      start_i = 1'b0;
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", stall_o); end
      total++; if (done_o !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done_o); end
      total++; if (result_o !== 32'h0) begin bad++; $display("FAIL reset_result got=%h exp=0", result_o); end
      rstn = 1'b1;
   endtask

   task automatic test_mul();
      logic [31:0] r; int d, s;
      run_op(MUL, 32'd7, 32'hFFFF_FFFD, r, d, s);
      total++; if (r !== 32'hFFFF_FFEB) begin bad++; $display("FAIL mul_res got=%h exp=ffffffeb", r); end
      total++; if (d !== 33) begin bad++; $display("FAIL mul_done_cycle got=%0d exp=33", d); end
      total++; if (s !== 33) begin bad++; $display("FAIL mul_stall_cycles got=%0d exp=33", s); end
      #1;
      total++; if (done_o !== 1'b0) begin bad++; $display("FAIL mul_done_single got=%b exp=0", done_o); end
      run_op(MULH, 32'h8000_0000, 32'h8000_0000, r, d, s);
      total++; if (r !== 32'h4000_0000) begin bad++; $display("FAIL mulh_res got=%h exp=40000000", r); end
      run_op(MULHU, 32'h8000_0000, 32'h8000_0000, r, d, s);
      total++; if (r !== 32'h4000_0000) begin bad++; $display("FAIL mulhu_res got=%h exp=40000000", r); end
      run_op(MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, d, s);
      total++; if (r !== 32'hFFFF_FFFE) begin bad++; $display("FAIL mulhu_max got=%h exp=fffffffe", r); end
      run_op(MULH, 32'hFFFF_FFFF, 32'h0000_0005, r, d, s);
      total++; if (r !== 32'hFFFF_FFFF) begin bad++; $display("FAIL mulh_neg got=%h exp=ffffffff", r); end
   endtask

   task automatic test_div();
      logic [31:0] r; int d, s;
      run_op(DIV, 32'hFFFF_FFF9, 32'd2, r, d, s);
      total++; if (r !== 32'hFFFF_FFFD) begin bad++; $display("FAIL div_res got=%h exp=fffffffd", r); end
      total++; if (d !== 33) begin bad++; $display("FAIL div_done_cycle got=%0d exp=33", d); end
      run_op(REM, 32'hFFFF_FFF9, 32'd2, r, d, s);
      total++; if (r !== 32'hFFFF_FFFF) begin bad++; $display("FAIL rem_res got=%h exp=ffffffff", r); end
      run_op(DIVU, 32'd100, 32'd7, r, d, s);
      total++; if (r !== 32'd14) begin bad++; $display("FAIL divu_res got=%h exp=0000000e", r); end
      run_op(REMU, 32'd100, 32'd7, r, d, s);
      total++; if (r !== 32'd2) begin bad++; $display("FAIL remu_res got=%h exp=00000002", r); end
      run_op(DIV, 32'd100, 32'hFFFF_FFF9, r, d, s);
      total++; if (r !== 32'hFFFF_FFF2) begin bad++; $display("FAIL div_negb got=%h exp=fffffff2", r); end
   endtask

   task automatic test_special();
      logic [31:0] r; int d, s;
      run_op(DIV, 32'd5, 32'd0, r, d, s);
      total++; if (r !== 32'hFFFF_FFFF) begin bad++; $display("FAIL div0_res got=%h exp=ffffffff", r); end
      total++; if (d !== 1) begin bad++; $display("FAIL div0_done_cycle got=%0d exp=1", d); end
      total++; if (s !== 1) begin bad++; $display("FAIL div0_stall_cycles got=%0d exp=1", s); end
      run_op(REMU, 32'd5, 32'd0, r, d, s);
      total++; if (r !== 32'd5) begin bad++; $display("FAIL remu0_res got=%h exp=00000005", r); end
      run_op(DIVU, 32'd5, 32'd0, r, d, s);
      total++; if (r !== 32'hFFFF_FFFF) begin bad++; $display("FAIL divu0_res got=%h exp=ffffffff", r); end
      run_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF, r, d, s);
      total++; if (r !== 32'h8000_0000) begin bad++; $display("FAIL div_ovf_res got=%h exp=80000000", r); end
      total++; if (d !== 1) begin bad++; $display("FAIL div_ovf_done_cycle got=%0d exp=1", d); end
      run_op(REM, 32'h8000_0000, 32'hFFFF_FFFF, r, d, s);
      total++; if (r !== 32'h0) begin bad++; $display("FAIL rem_ovf_res got=%h exp=00000000", r); end
      run_op(RSVD, 32'd9, 32'd9, r, d, s);
      total++; if (r !== 32'h0) begin bad++; $display("FAIL rsvd_res got=%h exp=00000000", r); end
      total++; if (d !== 1) begin bad++; $display("FAIL rsvd_done_cycle got=%0d exp=1", d); end
   endtask

   task automatic test_flush();
      logic [31:0] r; int d, s, nd;
      @(negedge clk);
      start_i = 1'b1; op_i = MUL; a_i = 32'd7; b_i = 32'd9;
      repeat (10) @(negedge clk);
      flush_i = 1'b1;
      #1;
      total++; if (stall_o !== 1'b1) begin bad++; $display("FAIL flush_busy_stall got=%b exp=1", stall_o); end
      @(negedge clk);
      flush_i = 1'b0; start_i = 1'b0;
      #1;
      total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL flush_next_stall got=%b exp=0", stall_o); end
      nd = 0;
      for (int c = 0; c < 40; c++) begin
         #1; if (done_o) nd++;
         @(negedge clk);
      end
      total++; if (nd !== 0) begin bad++; $display("FAIL flush_no_done got=%0d exp=0", nd); end
      run_op(MUL, 32'd3, 32'd4, r, d, s);
      total++; if (r !== 32'd12) begin bad++; $display("FAIL flush_then_mul got=%h exp=0000000c", r); end
      total++; if (d !== 33) begin bad++; $display("FAIL flush_then_mul_cycle got=%0d exp=33", d); end

      // flush_i in IDLE blocks acceptance
      @(negedge clk);
      start_i = 1'b1; flush_i = 1'b1; op_i = MUL; a_i = 32'd2; b_i = 32'd2;
      #1;
      total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL flush_idle_stall got=%b exp=0", stall_o); end
      @(negedge clk);
      start_i = 1'b0; flush_i = 1'b0;
      nd = 0;
      for (int c = 0; c < 40; c++) begin
         #1; if (done_o) nd++;
         @(negedge clk);
      end
      total++; if (nd !== 0) begin bad++; $display("FAIL flush_idle_no_done got=%0d exp=0", nd); end

      // flush_i in DONE suppresses the pulse
      start_i = 1'b1; op_i = MUL; a_i = 32'd5; b_i = 32'd5;
      repeat (33) @(negedge clk);
      flush_i = 1'b1;
      #1;
      total++; if (done_o !== 1'b0) begin bad++; $display("FAIL flush_done_pulse got=%b exp=0", done_o); end
      total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL flush_done_stall got=%b exp=0", stall_o); end
      @(negedge clk);
      flush_i = 1'b0; start_i = 1'b0;
      #1;
      total++; if (done_o !== 1'b0) begin bad++; $display("FAIL flush_done_after got=%b exp=0", done_o); end
   endtask

   task automatic test_reset_midop();
      logic [31:0] r; int d, s;
      @(negedge clk);
      start_i = 1'b1; op_i = MUL; a_i = 32'd5; b_i = 32'd6;
      repeat (5) @(negedge clk);
      rstn = 1'b0; start_i = 1'b0;
      @(negedge clk);
      #1;
      total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL rst_mid_stall got=%b exp=0", stall_o); end
      total++; if (done_o !== 1'b0) begin bad++; $display("FAIL rst_mid_done got=%b exp=0", done_o); end
      total++; if (result_o !== 32'h0) begin bad++; $display("FAIL rst_mid_result got=%h exp=0", result_o); end
      rstn = 1'b1;
      run_op(REMU, 32'd100, 32'd7, r, d, s);
      total++; if (r !== 32'd2) begin bad++; $display("FAIL rst_then_remu got=%h exp=00000002", r); end
      total++; if (d !== 33) begin bad++; $display("FAIL rst_then_remu_cycle got=%0d exp=33", d); end
   endtask

   task automatic test_back_to_back();
      int nd, t1, t2;
      logic [31:0] r1, r2;
      logic st1;
      nd = 0; t1 = -1; t2 = -1; r1 = '0; r2 = '0; st1 = 1'bx;
      @(negedge clk);
      start_i = 1'b1; op_i = DIVU; a_i = 32'd100; b_i = 32'd7;
      for (int c = 0; c < 120; c++) begin
         #1;
         if (done_o) begin
            nd++;
            if (t1 < 0) begin t1 = c; r1 = result_o; st1 = stall_o; end
            else if (t2 < 0) begin t2 = c; r2 = result_o; end
         end
         @(negedge clk);
         if (t1 >= 0 && c == t1) begin op_i = MUL; a_i = 32'hFFFF_FFFF; b_i = 32'd5; end
         if (t2 >= 0 && c == t2) start_i = 1'b0;
      end
      start_i = 1'b0;
      total++; if (nd !== 2) begin bad++; $display("FAIL b2b_pulses got=%0d exp=2", nd); end
      total++; if (t1 !== 33) begin bad++; $display("FAIL b2b_first_cycle got=%0d exp=33", t1); end
      total++; if (t2 - t1 !== 34) begin bad++; $display("FAIL b2b_spacing got=%0d exp=34", t2 - t1); end
      total++; if (r1 !== 32'd14) begin bad++; $display("FAIL b2b_divu got=%h exp=0000000e", r1); end
      total++; if (r2 !== 32'hFFFF_FFFB) begin bad++; $display("FAIL b2b_mul got=%h exp=fffffffb", r2); end
      total++; if (st1 !== 1'b0) begin bad++; $display("FAIL b2b_done_stall got=%b exp=0", st1); end
   endtask

   initial begin
      test_reset();
      test_mul();
      test_div();
      test_special();
      test_flush();
      test_reset_midop();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
